// File: rtl/spram_arb_pkg.sv
// Shared constants and types for the single-port RAM arbiter.
package spram_arb_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;

  typedef logic port_id_t;

  // One entry per issued RAM command; rd=0 marks a write or an idle slot.
  typedef struct packed {
    logic     rd;
    port_id_t id;
  } tag_t;

endpackage

// File: rtl/single_port_ram_arbiter_if.sv
// Request/response handshakes of both ports plus the RAM pin bundle.
interface single_port_ram_arbiter_if;
  import spram_arb_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req1_valid;
  logic              req1_ready;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;

  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic              ram_rwe;
  logic [DATA_W-1:0] ram_data_out;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output ram_addr, ram_data_in, ram_rwe,
    input  ram_data_out
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  ram_addr, ram_data_in, ram_rwe,
    output ram_data_out
  );

endinterface

// File: rtl/spram_arb_rr.sv
// Two-way grant logic: round-robin by default, port 0 fixed priority when
// SPRAM_ARB_FIXED_PRIO_EN is defined.
module spram_arb_rr (
`ifndef SPRAM_ARB_FIXED_PRIO_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic [1:0] i_req,
  output logic [1:0] o_grant_c
);

`ifdef SPRAM_ARB_FIXED_PRIO_EN

  assign o_grant_c = {i_req[1] & ~i_req[0], i_req[0]};

`else

  logic r_last;   // 1: port 1 won last time, so port 0 is preferred
  logic w_pick1;

  always_comb begin
    w_pick1 = i_req[1];
    if (i_req == 2'b11) begin
      w_pick1 = ~r_last;
    end
  end

  assign o_grant_c = {i_req[1] & w_pick1, i_req[0] & ~w_pick1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (|i_req) begin
      r_last <= w_pick1;
    end
  end

`endif

endmodule

// File: rtl/single_port_ram_arbiter.sv
// Shares one 64x8 single-port RAM between two requesters with a 2-cycle read
// pipeline. Optional build macro: SPRAM_ARB_FIXED_PRIO_EN.
module single_port_ram_arbiter
  import spram_arb_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  single_port_ram_arbiter_if.slave   bus
);

  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_sel1;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_data_in;
  logic              r_ram_rwe;
  tag_t              r_tag_s1;
  tag_t              r_tag_s2;
  logic              r_rsp0_valid;
  logic              r_rsp1_valid;
  logic [DATA_W-1:0] r_rsp0_rdata;
  logic [DATA_W-1:0] r_rsp1_rdata;

  assign w_req = {bus.req1_valid, bus.req0_valid};

  spram_arb_rr u_arb (
`ifndef SPRAM_ARB_FIXED_PRIO_EN
    .clk       (clk),
    .rst       (rst),
`endif
    .i_req     (w_req),
    .o_grant_c (w_grant)
  );

  assign bus.req0_ready = w_grant[0];
  assign bus.req1_ready = w_grant[1];

  assign w_sel1  = w_grant[1];
  assign w_we    = w_sel1 ? bus.req1_we    : bus.req0_we;
  assign w_addr  = w_sel1 ? bus.req1_addr  : bus.req0_addr;
  assign w_wdata = w_sel1 ? bus.req1_wdata : bus.req0_wdata;

  // Command registers, tag pipe and response demux
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ram_addr    <= '0;
      r_ram_data_in <= '0;
      r_ram_rwe     <= 1'b0;
      r_tag_s1      <= '0;
      r_tag_s2      <= '0;
      r_rsp0_valid  <= 1'b0;
      r_rsp1_valid  <= 1'b0;
      r_rsp0_rdata  <= '0;
      r_rsp1_rdata  <= '0;
    end else begin
      r_ram_rwe <= 1'b0;
      if (|w_grant) begin
        r_ram_addr    <= w_addr;
        r_ram_data_in <= w_wdata;
        r_ram_rwe     <= w_we;
      end
      r_tag_s1.rd <= (|w_grant) & ~w_we;
      r_tag_s1.id <= port_id_t'(w_sel1);
      r_tag_s2    <= r_tag_s1;

      r_rsp0_valid <= r_tag_s2.rd & (r_tag_s2.id == 1'b0);
      r_rsp1_valid <= r_tag_s2.rd & (r_tag_s2.id == 1'b1);
      if (r_tag_s2.rd && r_tag_s2.id == 1'b0) begin
        r_rsp0_rdata <= bus.ram_data_out;
      end
      if (r_tag_s2.rd && r_tag_s2.id == 1'b1) begin
        r_rsp1_rdata <= bus.ram_data_out;
      end
    end
  end

  assign bus.ram_addr    = r_ram_addr;
  assign bus.ram_data_in = r_ram_data_in;
  assign bus.ram_rwe     = r_ram_rwe;
  assign bus.rsp0_valid  = r_rsp0_valid;
  assign bus.rsp1_valid  = r_rsp1_valid;
  assign bus.rsp0_rdata  = r_rsp0_rdata;
  assign bus.rsp1_rdata  = r_rsp1_rdata;

endmodule
